// File: rtl/cmd_frame_initiator_pkg.sv
// Command-protocol definitions shared by the host-side initiator and the system controller decoder.
// Holds the frame header bytes, request encodings, frame lengths and FSM state encoding.
package cmd_frame_initiator_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        REQ_WR      = 2'd0,
        REQ_RD      = 2'd1,
        REQ_ALU_OP  = 2'd2,
        REQ_ALU_NOP = 2'd3
    } req_cmd_e;

    localparam int unsigned FRAME_LEN_WR      = 3;
    localparam int unsigned FRAME_LEN_RD      = 2;
    localparam int unsigned FRAME_LEN_ALU_OP  = 4;
    localparam int unsigned FRAME_LEN_ALU_NOP = 2;
    localparam int unsigned FRAME_MAX_LEN     = 4;
    localparam int unsigned FRAME_IDX_W       = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    function automatic logic [7:0] cmd_byte(input req_cmd_e cmd);
        logic [7:0] b;
        case (cmd)
            REQ_WR:      b = CMD_WR;
            REQ_RD:      b = CMD_RD;
            REQ_ALU_OP:  b = CMD_ALU_OP;
            REQ_ALU_NOP: b = CMD_ALU_NOP;
            default:     b = CMD_WR;
        endcase
        return b;
    endfunction

    function automatic logic [FRAME_IDX_W-1:0] frame_last_idx(input req_cmd_e cmd);
        logic [FRAME_IDX_W-1:0] idx;
        case (cmd)
            REQ_WR:      idx = FRAME_IDX_W'(FRAME_LEN_WR - 1);
            REQ_RD:      idx = FRAME_IDX_W'(FRAME_LEN_RD - 1);
            REQ_ALU_OP:  idx = FRAME_IDX_W'(FRAME_LEN_ALU_OP - 1);
            REQ_ALU_NOP: idx = FRAME_IDX_W'(FRAME_LEN_ALU_NOP - 1);
            default:     idx = '0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/cmd_frame_initiator_rsp_timer.sv
// Response-wait timer: synchronous clear, count enable, terminal flag at Timeout_cycles-1.
module rsp_timer
    import cmd_frame_initiator_pkg::*;
#(
    parameter int unsigned Timeout_cycles = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CountWidth = $clog2(Timeout_cycles);
    localparam logic [CountWidth-1:0] TermCount = CountWidth'(Timeout_cycles - 1);

    logic [CountWidth-1:0] r_count;

    assign o_terminal = (r_count == TermCount);

    // Saturates at the terminal value so a missed clear can never wrap into a false early timeout.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + CountWidth'(1);
        end
    end

endmodule

// File: rtl/cmd_frame_initiator.sv
// Host-side initiator: serialises one request into a command frame toward UART TX,
// then returns the single response byte from UART RX, or a timeout.
module cmd_frame_initiator
    import cmd_frame_initiator_pkg::*;
#(
    parameter int unsigned Data_width     = 8,
    parameter int unsigned Address_width  = 4,
    parameter int unsigned Timeout_cycles = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_cmd,
    input  logic [Address_width-1:0] req_addr,
    input  logic [Data_width-1:0]    req_data,
    input  logic [Data_width-1:0]    req_op_a,
    input  logic [Data_width-1:0]    req_op_b,
    input  logic [3:0]               req_fun,
    output logic [Data_width-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [Data_width-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rsp_valid,
    output logic [Data_width-1:0]    rsp_data,
    output logic                     rsp_timeout,
    output logic                     busy
);

    typedef logic [FRAME_MAX_LEN-1:0][Data_width-1:0] frame_t;

    state_e                 r_state;
    frame_t                 r_frame;
    frame_t                 w_frame;
    logic [FRAME_IDX_W-1:0] r_idx;
    logic [FRAME_IDX_W-1:0] r_last_idx;
    logic [FRAME_IDX_W-1:0] w_next_idx;
    logic [FRAME_IDX_W-1:0] w_last_idx;
    req_cmd_e               w_cmd;
    logic [Data_width-1:0]  w_cmd_byte;
    logic [Data_width-1:0]  w_addr_byte;
    logic [Data_width-1:0]  w_fun_byte;
    logic                   w_accept;
    logic                   w_timer_clear;
    logic                   w_timer_enable;
    logic                   w_timer_terminal;

    assign w_cmd       = req_cmd_e'(req_cmd);
    assign w_accept    = req_valid && req_ready;
    assign w_next_idx  = r_idx + FRAME_IDX_W'(1);
    assign w_last_idx  = frame_last_idx(w_cmd);
    assign w_cmd_byte  = Data_width'(cmd_byte(w_cmd));
    assign w_addr_byte = Data_width'(req_addr);
    assign w_fun_byte  = Data_width'(req_fun);

    // Whole frame is built from the request fields and captured in one cycle at acceptance.
    always_comb begin
        w_frame    = '0;
        w_frame[0] = w_cmd_byte;
        case (w_cmd)
            REQ_WR: begin
                w_frame[1] = w_addr_byte;
                w_frame[2] = req_data;
            end
            REQ_RD: begin
                w_frame[1] = w_addr_byte;
            end
            REQ_ALU_OP: begin
                w_frame[1] = req_op_a;
                w_frame[2] = req_op_b;
                w_frame[3] = w_fun_byte;
            end
            REQ_ALU_NOP: begin
                w_frame[1] = w_fun_byte;
            end
            default: ;
        endcase
    end

    // Timer is held clear outside WAIT_RSP, so it reads 0 on the first wait cycle.
    assign w_timer_enable = (r_state == WAIT_RSP);
    assign w_timer_clear  = !w_timer_enable;

    rsp_timer #(
        .Timeout_cycles(Timeout_cycles)
    ) u_rsp_timer (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_terminal(w_timer_terminal)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_frame     <= '0;
            r_idx       <= '0;
            r_last_idx  <= '0;
            req_ready   <= 1'b1;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_frame    <= w_frame;
                        r_last_idx <= w_last_idx;
                        r_idx      <= '0;
                        tx_data    <= w_frame[0];
                        tx_valid   <= 1'b1;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (r_idx == r_last_idx) begin
                            tx_valid <= 1'b0;
                            r_state  <= WAIT_RSP;
                        end else begin
                            r_idx   <= w_next_idx;
                            tx_data <= r_frame[w_next_idx];
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response arriving on the terminal cycle takes priority over the timeout.
                    if (rx_valid) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= rx_data;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_timer_terminal) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_frame     <= '0;
                    r_idx       <= '0;
                    r_last_idx  <= '0;
                    req_ready   <= 1'b1;
                    tx_valid    <= 1'b0;
                    tx_data     <= '0;
                    rsp_data    <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_initiator.sv
// Directed scoreboard bench for cmd_frame_initiator: expected frame bytes and responses are
// queued when stimulus is driven and compared when the DUT handshakes or pulses rsp_valid.
module tb_cmd_frame_initiator;

    localparam int unsigned TO = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_cmd = '0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [7:0] req_op_a = '0;
    logic [7:0] req_op_b = '0;
    logic [3:0] req_fun = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;

    always #5 CLK = ~CLK;

    cmd_frame_initiator #(
        .Data_width    (8),
        .Address_width (4),
        .Timeout_cycles(TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .req_fun    (req_fun),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } tx_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       timeout;
        int         cyc;
    } rsp_exp_t;

    tx_exp_t    tx_q[$];
    rsp_exp_t   rsp_q[$];
    int         n_total = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] hold_data = '0;
    bit         s_req_ready = 1'b0;
    int         s_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        tx_exp_t  te;
        rsp_exp_t re;
        if (tx_valid) begin
            if (stall_prev) check("tx_hold", 32'(tx_data), 32'(hold_data));
            if (tx_ready) begin
                check("tx_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) begin
                    te = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(te.data));
                    if (te.cyc >= 0) check("tx_cycle", 32'(cyc), 32'(te.cyc));
                end
            end
            stall_prev = !tx_ready;
            hold_data  = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
        if (rsp_valid) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                re = rsp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(re.data));
                check("rsp_timeout", 32'(rsp_timeout), 32'(re.timeout));
                check("rsp_cycle", 32'(cyc), 32'(re.cyc));
            end
            check("rsp_req_ready", 32'(req_ready), 32'd1);
            check("rsp_busy", 32'(busy), 32'd0);
        end
    endtask

    // One clock cycle: observe at the falling edge, return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge CLK);
        monitor();
        s_req_ready = req_ready;
        s_cyc       = cyc;
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_frame(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data,
                              input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                              input int t, input bit timed, output int len);
        logic [7:0] f[$];
        f.delete();
        case (cmd)
            2'd0: begin f.push_back(8'hAA); f.push_back({4'h0, addr}); f.push_back(data); end
            2'd1: begin f.push_back(8'hBB); f.push_back({4'h0, addr}); end
            2'd2: begin f.push_back(8'hCC); f.push_back(a); f.push_back(b); f.push_back({4'h0, fun}); end
            default: begin f.push_back(8'hDD); f.push_back({4'h0, fun}); end
        endcase
        len = f.size();
        for (int i = 0; i < len; i++) begin
            tx_exp_t e;
            e.data = f[i];
            e.cyc  = timed ? t + 1 + i : -1;
            tx_q.push_back(e);
        end
    endtask

    task automatic send_req(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data,
                            input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                            input bit timed, output int t, output int len);
        req_cmd   = cmd;
        req_addr  = addr;
        req_data  = data;
        req_op_a  = a;
        req_op_b  = b;
        req_fun   = fun;
        req_valid = 1'b1;
        t   = -1;
        len = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_req_ready) begin
                t = s_cyc;
                break;
            end
        end
        check("req_accepted", 32'(t >= 0), 32'd1);
        req_valid = 1'b0;
        req_cmd   = 2'($urandom);
        req_addr  = 4'($urandom);
        req_data  = 8'($urandom);
        req_op_a  = 8'($urandom);
        req_op_b  = 8'($urandom);
        req_fun   = 4'($urandom);
        if (t >= 0) push_frame(cmd, addr, data, a, b, fun, t, timed, len);
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic expect_rsp(input logic [7:0] d, input logic to, input int c);
        rsp_exp_t e;
        e.data    = d;
        e.timeout = to;
        e.cyc     = c;
        rsp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (rsp_q.size() != 0 || tx_q.size() != 0); i++) tick();
        check("drain_tx", 32'(tx_q.size()), 32'd0);
        check("drain_rsp", 32'(rsp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int t2;
        int len;
        int e;

        #2 RST = 1'b0;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();

        // WR with tx_ready tied high, response at T+10
        send_req(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b1, t, len);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_req_ready", 32'(req_ready), 32'd0);
        goto_cycle(t + 10);
        expect_rsp(8'h3C, 1'b0, t + 11);
        pulse_rx(8'h3C);
        wait_drain(40);

        // ALU_OP with tx_ready toggling: each byte held until accepted
        send_req(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 1'b0, t, len);
        for (int k = 0; k < 16 && tx_q.size() != 0; k++) begin
            tx_ready = (k % 2 == 0);
            tick();
        end
        tx_ready = 1'b1;
        check("aluop_bytes_sent", 32'(tx_q.size()), 32'd0);
        expect_rsp(8'h46, 1'b0, cyc + 1);
        pulse_rx(8'h46);
        wait_drain(40);

        // RD with no response: timeout exactly TO cycles after WAIT_RSP entry
        send_req(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, t, len);
        expect_rsp(8'h00, 1'b1, t + len + 1 + TO);
        wait_drain(60);

        // ALU_NOP with rx pulse during SEND (ignored), then a real response
        send_req(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 1'b1, t, len);
        pulse_rx(8'h55);
        goto_cycle(t + 6);
        expect_rsp(8'h07, 1'b0, t + 7);
        pulse_rx(8'h07);
        wait_drain(40);

        // rx pulse in IDLE must not produce a response
        pulse_rx(8'hEE);
        tick();
        tick();

        // Response on the timer-terminal cycle wins over timeout
        send_req(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h9, 1'b1, t, len);
        e = t + len + 1;
        goto_cycle(e + TO - 1);
        expect_rsp(8'hA5, 1'b0, e + TO);
        pulse_rx(8'hA5);
        wait_drain(40);

        // Reset asserted after the second WR byte abandons the frame
        send_req(2'd0, 4'h7, 8'h99, 8'h00, 8'h00, 4'h0, 1'b1, t, len);
        tick();
        tick();
        RST = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_unsent_bytes", 32'(tx_q.size()), 32'd1);
        tx_q.delete();
        tick();
        tick();
        RST = 1'b1;
        tick();
        tick();
        send_req(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, t, len);
        goto_cycle(t + 5);
        expect_rsp(8'h3A, 1'b0, t + 6);
        pulse_rx(8'h3A);
        wait_drain(40);

        // Back-to-back: second request held high, accepted on the rsp_valid cycle
        send_req(2'd0, 4'h9, 8'h5A, 8'h00, 8'h00, 4'h0, 1'b1, t, len);
        req_cmd   = 2'd2;
        req_op_a  = 8'h77;
        req_op_b  = 8'h88;
        req_fun   = 4'hF;
        req_valid = 1'b1;
        goto_cycle(t + 6);
        expect_rsp(8'h5A, 1'b0, t + 7);
        pulse_rx(8'h5A);
        send_req(2'd2, 4'h0, 8'h00, 8'h77, 8'h88, 4'hF, 1'b1, t2, len);
        check("b2b_accept_cycle", 32'(t2), 32'(t + 7));
        goto_cycle(t2 + len + 3);
        expect_rsp(8'h1E, 1'b0, cyc + 1);
        pulse_rx(8'h1E);
        wait_drain(40);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cmd_frame_initiator.md
Name: cmd_frame_initiator

Overview:
Host-side initiator for the UART command protocol that the system controller decodes.
- Accepts one high-level request at a time.
- Serialises it into the command byte frame (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) toward a UART TX.
- Waits for the single response byte from a UART RX and returns it, with timeout.
- Sits in the test-host/bridge side of the system, mirroring the controller's frame decoder.

Parameters:
Data_width, 8, byte width of frame bytes and response
Address_width, 4, register-file address width (zero-extended into the address byte)
Timeout_cycles, 1024, CLK cycles in WAIT_RSP before declaring timeout (min 2)

Ports:
CLK  input  1  clock
RST  input  1  reset; asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready
req_cmd  input  2  0=WR(0xAA), 1=RD(0xBB), 2=ALU_OP(0xCC), 3=ALU_NOP(0xDD)
req_addr  input  Address_width  register address (WR, RD)
req_data  input  Data_width  write data (WR)
req_op_a  input  Data_width  ALU operand A (ALU_OP)
req_op_b  input  Data_width  ALU operand B (ALU_OP)
req_fun  input  4  ALU function (ALU_OP, ALU_NOP), zero-extended to a byte
tx_data  output  Data_width  frame byte to UART TX
tx_valid  output  1  tx_data valid; byte consumed when tx_valid & tx_ready
tx_ready  input  1  UART TX can accept a byte
rx_data  input  Data_width  response byte from UART RX
rx_valid  input  1  single-cycle strobe, rx_data valid
rsp_valid  output  1  one-cycle pulse, transaction finished
rsp_data  output  Data_width  response byte (0 on timeout)
rsp_timeout  output  1  qualifies rsp_valid: no response within Timeout_cycles
busy  output  1  high in any state except IDLE

Behaviour:
- All outputs are registered. Reset values:
  - req_ready=1.
  - tx_valid, rsp_valid, rsp_timeout, busy = 0.
  - tx_data and rsp_data = 0.
  - State IDLE; byte index and timer = 0.
- Frames:
  - WR: AA, addr, data (3 bytes).
  - RD: BB, addr (2 bytes).
  - ALU_OP: CC, A, B, fun (4 bytes).
  - ALU_NOP: DD, fun (2 bytes).
- Every frame expects exactly one response byte.
- All request fields are latched at the acceptance cycle. Input changes afterwards have no effect.
- States and transitions:
  - IDLE: on accept (cycle T), load frame, idx=0, go to SEND.
  - SEND: tx_valid=1 with tx_data=byte[idx] from cycle T+1.
    - tx_data is held stable while tx_valid & !tx_ready.
    - On handshake, idx++ and the next byte is presented the following cycle.
    - On handshake of the last byte, tx_valid drops next cycle and the state goes to WAIT_RSP with timer cleared.
  - WAIT_RSP: timer increments each cycle.
    - rx_valid at cycle R: rsp_valid=1, rsp_data=rx_data, rsp_timeout=0 at R+1; go to IDLE.
    - Timer reaching Timeout_cycles-1 without rx_valid: rsp_valid=1, rsp_timeout=1, rsp_data=0; go to IDLE.
    - rx_valid in the same cycle as timer terminal: response wins, no timeout.
- Latency with tx_ready tied 1:
  - Bytes on cycles T+1..T+len.
  - WAIT_RSP entered at T+len+1.
  - Timeout rsp_valid at T+len+1+Timeout_cycles.
- req_ready returns to 1 in the same cycle rsp_valid pulses, so back-to-back requests are allowed.
- rx_valid outside WAIT_RSP (IDLE, SEND) is ignored and discarded.
- tx_ready while tx_valid=0 has no effect.
- Undefined idx values are never reached. The default state branch returns to IDLE with outputs at reset values.
- RST asserted mid-frame or mid-wait: immediate return to reset values. The partial frame is abandoned and no rsp_valid is issued.

Decomposition:
- Shared package holds:
  - Command byte constants: CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - req_cmd encodings.
  - Frame lengths: 3, 2, 4, 2.
  - State encoding: IDLE, SEND, WAIT_RSP.
- Package is shared with the system controller.
- One sub-module, rsp_timer: clear/enable counter with terminal flag, width clog2(Timeout_cycles).

Test Plan:
1. WR addr=4'h5 data=8'h3C, tx_ready=1 -> tx bytes AA,05,3C on T+1..T+3. rx 8'h3C at T+10 -> rsp_valid at T+11, rsp_data=3C, rsp_timeout=0.
2. ALU_OP A=8'h12 B=8'h34 fun=4'h0 with tx_ready toggling 1,0,1,0 -> bytes CC,12,34,00 each held stable until handshake. rx 8'h46 -> rsp_data=46.
3. RD addr=4'h2, no rx, Timeout_cycles=16 -> rsp_valid with rsp_timeout=1, rsp_data=0 exactly 16 cycles after WAIT_RSP entry. req_ready=1 the same cycle.
4. ALU_NOP fun=4'h3 with rx_valid pulsed during SEND -> pulse ignored, bytes DD,03 sent. Later rx 8'h07 -> rsp_data=07. Also: rx_valid on the timer-terminal cycle -> rsp_timeout=0.
5. RST low after the second byte of a WR frame -> next cycle tx_valid=0, busy=0, req_ready=1, no rsp_valid. A new RD request then runs cleanly (BB, addr).
6. Back-to-back: second req_valid held high during the first transaction -> accepted only on the rsp_valid cycle. Fields changed after acceptance do not alter the emitted bytes.
